// File: rtl/din_debounce.sv
// Input conditioner: two-flop synchroniser, stability-qualified level FSM,
// registered edge strobes and a saturating count of aborted qualifications.
module din_debounce #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 20
) (
   input  logic       clk,
   input  logic       ret,
   input  logic       key_in,
   output logic       key_out,
   output logic       key_rise,
   output logic       key_fall,
   output logic [7:0] glitch_cnt,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      LOW   = 2'd0,
      CHK_H = 2'd1,
      HIGH  = 2'd2,
      CHK_L = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             s1_q, s2_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_out_q, key_out_d;
   logic             key_rise_q, key_rise_d;
   logic             key_fall_q, key_fall_d;
   logic [7:0]       glitch_q, glitch_d;
   logic             glitch_inc;

   always_ff @(posedge clk or posedge ret) begin
      if (ret) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         state_q    <= LOW;
         cnt_q      <= '0;
         key_out_q  <= 1'b0;
         key_rise_q <= 1'b0;
         key_fall_q <= 1'b0;
         glitch_q   <= 8'd0;
      end else begin
         s1_q       <= key_in;
         s2_q       <= s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         key_out_q  <= key_out_d;
         key_rise_q <= key_rise_d;
         key_fall_q <= key_fall_d;
         glitch_q   <= glitch_d;
      end
   end

   // Any reversal of s2 inside a CHK window aborts it and counts a glitch.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      glitch_inc = 1'b0;
      case (state_q)
         LOW: begin
            if (s2_q) begin
               state_d = CHK_H;
               cnt_d   = '0;
            end
         end
         CHK_H: begin
            if (!s2_q) begin
               state_d    = LOW;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end else if (cnt_q == LAST) begin
               state_d = HIGH;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (!s2_q) begin
               state_d = CHK_L;
               cnt_d   = '0;
            end
         end
         CHK_L: begin
            if (s2_q) begin
               state_d    = HIGH;
               cnt_d      = '0;
               glitch_inc = 1'b1;
            end else if (cnt_q == LAST) begin
               state_d = LOW;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = LOW;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so they register on the
   // same edge the FSM commits the transition.
   always_comb begin
      key_out_d  = (state_d == HIGH) || (state_d == CHK_L);
      key_rise_d = (state_q == CHK_H) && (state_d == HIGH);
      key_fall_d = (state_q == CHK_L) && (state_d == LOW);
      glitch_d   = glitch_q;
      if (glitch_inc && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   assign key_out    = key_out_q;
   assign key_rise   = key_rise_q;
   assign key_fall   = key_fall_q;
   assign glitch_cnt = glitch_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce with STABLE_CYCLES=4: qualification latency,
// glitch rejection, bounce, release, saturation and async reset mid-window.
module tb_din_debounce;

   logic       clk;
   logic       ret;
   logic       key_in;
   logic       key_out;
   logic       key_rise;
   logic       key_fall;
   logic [7:0] glitch_cnt;
   logic [1:0] state_dbg;

   int checks = 0;
   int errors = 0;

   din_debounce #(.STABLE_CYCLES(4), .CNT_W(20)) dut (
      .clk        (clk),
      .ret        (ret),
      .key_in     (key_in),
      .key_out    (key_out),
      .key_rise   (key_rise),
      .key_fall   (key_fall),
      .glitch_cnt (glitch_cnt),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] bounce;
      int         rises;
      bounce = 6'b101101;

      // Reset, checked while ret is still high.
      ret    = 1'b1;
      key_in = 1'b0;
      #2;
      chk("rst_key_out", {7'd0, key_out}, 8'd0);
      chk("rst_rise", {7'd0, key_rise}, 8'd0);
      chk("rst_fall", {7'd0, key_fall}, 8'd0);
      chk("rst_glitch", glitch_cnt, 8'd0);
      chk("rst_state", {6'd0, state_dbg}, 8'd0);
      tick(); tick();
      ret = 1'b0;
      tick();

      // Clean rise: out stays low through edges k..k+5, rises at k+6.
      key_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("rise_wait_out", {7'd0, key_out}, 8'd0);
         chk("rise_wait_strobe", {7'd0, key_rise}, 8'd0);
      end
      tick();
      chk("rise_out", {7'd0, key_out}, 8'd1);
      chk("rise_strobe", {7'd0, key_rise}, 8'd1);
      chk("rise_no_fall", {7'd0, key_fall}, 8'd0);
      tick();
      chk("rise_strobe_end", {7'd0, key_rise}, 8'd0);
      chk("rise_out_held", {7'd0, key_out}, 8'd1);
      chk("rise_state_high", {6'd0, state_dbg}, 8'd2);
      chk("rise_glitch", glitch_cnt, 8'd0);

      // Release: out stays high through the window, falls at k+6.
      key_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("fall_wait_out", {7'd0, key_out}, 8'd1);
         chk("fall_wait_strobe", {7'd0, key_fall}, 8'd0);
      end
      tick();
      chk("fall_out", {7'd0, key_out}, 8'd0);
      chk("fall_strobe", {7'd0, key_fall}, 8'd1);
      chk("fall_no_rise", {7'd0, key_rise}, 8'd0);
      tick();
      chk("fall_strobe_end", {7'd0, key_fall}, 8'd0);

      // Short glitch: three high samples never reach the last count.
      key_in = 1'b1;
      tick(); tick(); tick();
      key_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch3_out", {7'd0, key_out}, 8'd0);
         chk("glitch3_rise", {7'd0, key_rise}, 8'd0);
      end
      chk("glitch3_cnt", glitch_cnt, 8'd1);

      // Bounce 1,0,1,1,0,1 then steady 1: two aborts, one rise 6 clocks
      // after the final 0->1 sample.
      rises = 0;
      for (int i = 5; i >= 0; i--) begin
         key_in = bounce[i];
         tick();
         chk("bounce_out", {7'd0, key_out}, 8'd0);
         if (key_rise) rises++;
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bounce_settle_out", {7'd0, key_out}, 8'd0);
         if (key_rise) rises++;
      end
      tick();
      chk("bounce_rise_out", {7'd0, key_out}, 8'd1);
      chk("bounce_rise_strobe", {7'd0, key_rise}, 8'd1);
      if (key_rise) rises++;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (key_rise) rises++;
      end
      chk("bounce_rise_count", rises[7:0], 8'd1);
      chk("bounce_glitch", glitch_cnt, 8'd3);

      // Release from HIGH, then a 2-clock high glitch while LOW.
      key_in = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      chk("rel_out", {7'd0, key_out}, 8'd0);
      chk("rel_strobe", {7'd0, key_fall}, 8'd1);
      tick();
      key_in = 1'b1;
      tick(); tick();
      key_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("glitch2_out", {7'd0, key_out}, 8'd0);
         chk("glitch2_strobes", {6'd0, key_rise, key_fall}, 8'd0);
      end
      chk("glitch2_cnt", glitch_cnt, 8'd4);

      // Saturation: 300 more aborted glitches must stop at 255.
      for (int n = 0; n < 300; n++) begin
         key_in = 1'b1;
         tick();
         chk("sat_out", {7'd0, key_out}, 8'd0);
         tick();
         key_in = 1'b0;
         for (int i = 0; i < 4; i++) tick();
         chk("sat_out_low", {7'd0, key_out}, 8'd0);
      end
      chk("sat_cnt", glitch_cnt, 8'd255);

      // Async reset in CHK_L with key_out=1.
      key_in = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("pre_rst_out", {7'd0, key_out}, 8'd1);
      key_in = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst_state_chkl", {6'd0, state_dbg}, 8'd3);
      chk("pre_rst_out_held", {7'd0, key_out}, 8'd1);
      #2;
      ret = 1'b1;
      #1;
      chk("async_rst_out", {7'd0, key_out}, 8'd0);
      chk("async_rst_fall", {7'd0, key_fall}, 8'd0);
      chk("async_rst_glitch", glitch_cnt, 8'd0);
      chk("async_rst_state", {6'd0, state_dbg}, 8'd0);
      key_in = 1'b1;
      #1;
      ret = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_wait_out", {7'd0, key_out}, 8'd0);
         chk("post_rst_no_fall", {7'd0, key_fall}, 8'd0);
      end
      tick();
      chk("post_rst_out", {7'd0, key_out}, 8'd1);
      chk("post_rst_rise", {7'd0, key_rise}, 8'd1);
      chk("post_rst_glitch", glitch_cnt, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/din_debounce.md
# din_debounce

Input conditioning stage that sits directly upstream of the serial-ones sequence detector and drives its `din` input. It synchronises an asynchronous, bouncy external level (switch or key) into the `clk` domain and accepts a new level only after it has been stable for `STABLE_CYCLES` consecutive clocks. It also emits single-cycle edge strobes and counts rejected glitches for bring-up diagnostics.

## Interface
- `STABLE_CYCLES`, 16, consecutive stable synchronised samples required to accept a level change; legal range 2 .. 2^`CNT_W`-1.
- `CNT_W`, 20, width of the stability counter.
- `clk`  input  1  system clock, all logic on rising edge.
- `ret`  input  1  reset, asynchronous, active-high; all flops clear immediately on assertion.
- `key_in`  input  1  raw asynchronous input level.
- `key_out`  output  1  debounced level; connects to the detector's `din`.
- `key_rise`  output  1  one-cycle strobe on the cycle `key_out` first reads 1.
- `key_fall`  output  1  one-cycle strobe on the cycle `key_out` first reads 0.
- `glitch_cnt`  output  8  saturating count of aborted qualifications.

## Operation
- Synchroniser: two flops `s1 <= key_in`, `s2 <= s1`, both reset to 0. The FSM sees only `s2`.
- FSM states: LOW, CHK_H, HIGH, CHK_L (binary encoded). Reset state is LOW, and `cnt` resets to 0.
- LOW: if `s2`=1, go to CHK_H and set `cnt`=0. Otherwise stay.
- CHK_H:
  - If `s2`=0: go to LOW, set `cnt`=0, and increment `glitch_cnt`.
  - Else if `cnt`=`STABLE_CYCLES`-1: go to HIGH.
  - Else: `cnt` <= `cnt`+1.
- HIGH: if `s2`=0, go to CHK_L and set `cnt`=0. Otherwise stay.
- CHK_L: mirror of CHK_H. `s2`=1 returns to HIGH and increments `glitch_cnt`; `cnt`=`STABLE_CYCLES`-1 with `s2`=0 goes to LOW.
- Illegal or unreachable state encodings go to LOW with `cnt`=0.
- `key_out` is registered. It is 1 exactly when the state is HIGH or CHK_L, so it holds the old level throughout a qualification window.
- `key_rise` is registered and is 1 only on the cycle after a CHK_H→HIGH transition. `key_fall` is the same for CHK_L→LOW. The two strobes are never high together.
- `glitch_cnt` saturates at 255 and never wraps. Only `ret` clears it.
- `cnt` is only compared against `STABLE_CYCLES`-1, so it never overflows.

## Timing
- Reset values: `key_out`=0, `key_rise`=0, `key_fall`=0, `glitch_cnt`=0, state LOW, `s1`=`s2`=0.
- Latency, with edge k as the first `clk` edge that samples the new `key_in` level into `s1`:
  - `s2` updates at k+1.
  - The FSM enters the CHK state at k+2.
  - `key_out` and the matching strobe change at edge k+2+`STABLE_CYCLES`, provided the level is held through edge k+1+`STABLE_CYCLES`.
  - Total latency is `STABLE_CYCLES`+2 clocks.
- A reversal of `s2` on any cycle inside the CHK window aborts the window. The abort happens on that edge, and `key_out` never toggles.
- A re-reversal right after an abort restarts qualification from `cnt`=0. The previous partial count is discarded.
- Asserting `ret` mid-qualification or while `key_out`=1 forces all reset values immediately. After `ret` deasserts, a `key_in` that is still high needs the full `STABLE_CYCLES`+2 latency again.
- A held level produces no strobes. Strobes are exactly one cycle wide.

## Test plan
(All scenarios use `STABLE_CYCLES`=4.)
- Clean rise: `ret` pulse, then `key_in` 0→1 held. → `key_out` rises 6 clocks after the first sampling edge, `key_rise`=1 for exactly that one cycle, `glitch_cnt`=0.
- Short glitch: from LOW, `key_in`=1 for 3 clocks, then 0. → `key_out` stays 0, no strobes, `glitch_cnt`=1.
- Bounce then settle: from LOW, `key_in` pattern 1,0,1,1,0,1 followed by steady 1. → exactly one `key_rise`, 6 clocks after the final 0→1 sample, `glitch_cnt`=2.
- Release: from HIGH, `key_in` 1→0 held. → `key_out` falls 6 clocks later with a single `key_fall` pulse. Then a 2-clock high glitch → `key_out` stays 0, `glitch_cnt`+1.
- Saturation: 300 aborted 2-clock glitches. → `glitch_cnt`=255, no wrap, `key_out` constant 0.
- Async reset mid-window: assert `ret` between clock edges while in CHK_L with `key_out`=1. → `key_out`=0 immediately (before the next edge), no `key_fall` strobe, `glitch_cnt`=0. If `key_in` is held 1 after release, `key_out` returns to 1 after 6 clocks.
